// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent down-counting timers sharing one
// free-running prescaler, behind a byte-wide memory-mapped CPU port.
//
// Optional feature macro: MULTI_TIMER_CASCADE_EN
//   When defined, ctrl bit4 (CASC) exists on channels 1..CHANNELS-1. A channel
//   with CASC=1 steps on the expiry pulse of the channel below it instead of
//   on the prescaler tick. When undefined, bit4 reads 0 and writes to it are
//   ignored.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   addr     register address (CPU address low byte)
//   wr       single-cycle write strobe (chip select applied upstream)
//   rd       single-cycle read strobe (chip select applied upstream)
//   din      write data
//   dout     read data, combinational from addr
//   irq_n    registered active-low interrupt request
//   tick     one-cycle pulse at every prescaler wrap
//
// Bus protocol: wr and rd are one-cycle strobes with no handshake. A write
// takes effect at the clock edge that ends the strobe cycle. dout always
// reflects addr; rd only matters at +4, where it captures the snapshot.
//
// Register map (channel c at c*16):
//   +0..+3 reload bytes (LE, RW)   +4 live count[7:0] (rd -> snapshot)
//   +5..+7 snapshot bytes 1..3     +8 ctrl {CASC,RESTART,IE,AUTO,EN}
//   0x80 STATUS (pending, W1C)     0x81 IRQMASK (pending & IE, RO)
module multi_timer #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 16,
    parameter int PRESCALE   = 24000,
    parameter int PRESCALE_W = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] addr,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq_n,
    output logic       tick
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] pre_cnt;

    // Channel state; the FSM state doubles as the EN bit of ctrl.
    chan_state_t         state      [CHANNELS];
    chan_state_t         state_nxt  [CHANNELS];
    logic [WIDTH-1:0]    reload     [CHANNELS];
    logic [WIDTH-1:0]    reload_nxt [CHANNELS];
    logic [WIDTH-1:0]    count      [CHANNELS];
    logic [WIDTH-1:0]    count_nxt  [CHANNELS];
    logic [WIDTH-1:0]    snap       [CHANNELS];
    logic [WIDTH-1:0]    snap_nxt   [CHANNELS];
    logic [CHANNELS-1:0] auto_mode;
    logic [CHANNELS-1:0] auto_nxt;
    logic [CHANNELS-1:0] ie;
    logic [CHANNELS-1:0] ie_nxt;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] pending_nxt;
`ifdef MULTI_TIMER_CASCADE_EN
    logic [CHANNELS-1:0] casc;
    logic [CHANNELS-1:0] casc_nxt;
`endif

    // ------------------------------------------------------------------
    // Prescaler: tick is registered from the terminal count, so it is high
    // in exactly the cycle the counter shows 0 again.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= (pre_cnt == PRE_LAST);
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRESCALE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel next-state logic. Channels are evaluated in ascending order so
    // that a cascaded channel can see the expiry of the one below it within
    // the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        logic        sel;
        logic        ctrl_wr;
        logic        step;
        logic [31:0] rl_ext;
`ifdef MULTI_TIMER_CASCADE_EN
        logic        expire;
        logic        prev_exp;
        prev_exp = 1'b0;
        casc_nxt = casc;
`endif
        auto_nxt    = auto_mode;
        ie_nxt      = ie;
        pending_nxt = pending;
        // W1C first; an expiry below sets the bit again, so set wins.
        if (wr && addr == 8'h80) begin
            pending_nxt = pending & ~din[CHANNELS-1:0];
        end
        for (int c = 0; c < CHANNELS; c++) begin
            state_nxt[c]  = state[c];
            reload_nxt[c] = reload[c];
            count_nxt[c]  = count[c];
            snap_nxt[c]   = snap[c];
            sel     = !addr[7] && (addr[6:4] == 3'(c));
            ctrl_wr = wr && sel && (addr[3:0] == 4'h8);
            step    = tick;
`ifdef MULTI_TIMER_CASCADE_EN
            expire = 1'b0;
            if (casc[c]) begin
                step = prev_exp;
            end
`endif
            // Reload bytes: widen, patch one byte, truncate back so that
            // bits at or above WIDTH are silently dropped.
            rl_ext = 32'(reload[c]);
            if (wr && sel && addr[3:2] == 2'b00) begin
                rl_ext[{addr[1:0], 3'b000} +: 8] = din;
                reload_nxt[c] = rl_ext[WIDTH-1:0];
            end
            if (rd && sel && addr[3:0] == 4'h4) begin
                snap_nxt[c] = count[c];
            end

            // A ctrl write pre-empts any step arriving in the same cycle.
            if (ctrl_wr) begin
                state_nxt[c] = din[0] ? RUN : IDLE;
                auto_nxt[c]  = din[1];
                ie_nxt[c]    = din[2];
`ifdef MULTI_TIMER_CASCADE_EN
                casc_nxt[c]  = (c != 0) && din[4];
`endif
                if ((state[c] == IDLE && din[0]) || din[3]) begin
                    count_nxt[c] = reload[c];
                end
            end else if (state[c] == RUN && step) begin
                if (count[c] == '0) begin
`ifdef MULTI_TIMER_CASCADE_EN
                    expire = 1'b1;
`endif
                    pending_nxt[c] = 1'b1;
                    if (auto_mode[c]) begin
                        count_nxt[c] = reload[c];
                    end else begin
                        state_nxt[c] = IDLE;
                    end
                end else begin
                    count_nxt[c] = count[c] - WIDTH'(1);
                end
            end
`ifdef MULTI_TIMER_CASCADE_EN
            prev_exp = expire;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state[c]  <= IDLE;
                reload[c] <= '0;
                count[c]  <= '0;
                snap[c]   <= '0;
            end
            auto_mode <= '0;
            ie        <= '0;
            pending   <= '0;
`ifdef MULTI_TIMER_CASCADE_EN
            casc      <= '0;
`endif
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state[c]  <= state_nxt[c];
                reload[c] <= reload_nxt[c];
                count[c]  <= count_nxt[c];
                snap[c]   <= snap_nxt[c];
            end
            auto_mode <= auto_nxt;
            ie        <= ie_nxt;
            pending   <= pending_nxt;
`ifdef MULTI_TIMER_CASCADE_EN
            casc      <= casc_nxt;
`endif
        end
    end

    // Interrupt: one register stage after pending/IE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_n <= 1'b1;
        end else begin
            irq_n <= ~|(pending & ie);
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        logic [31:0] rd_rl;
        logic [31:0] rd_sn;
        logic        casc_bit;
        dout  = 8'h00;
        rd_rl = '0;
        rd_sn = '0;
        casc_bit = 1'b0;
        if (addr == 8'h80) begin
            dout = 8'(pending);
        end else if (addr == 8'h81) begin
            dout = 8'(pending & ie);
        end else if (!addr[7]) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (addr[6:4] == 3'(c)) begin
                    rd_rl = 32'(reload[c]);
                    rd_sn = 32'(snap[c]);
`ifdef MULTI_TIMER_CASCADE_EN
                    casc_bit = casc[c];
`endif
                    case (addr[3:0])
                        4'h0, 4'h1, 4'h2, 4'h3: dout = rd_rl[{addr[1:0], 3'b000} +: 8];
                        4'h4:                   dout = count[c][7:0];
                        4'h5, 4'h6, 4'h7:       dout = rd_sn[{addr[1:0], 3'b000} +: 8];
                        4'h8:                   dout = {3'b000, casc_bit, 1'b0, ie[c],
                                                        auto_mode[c], state[c] == RUN};
                        default:                dout = 8'h00;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Testbench for multi_timer (CHANNELS=4, WIDTH=16, PRESCALE=4).
// Reads are scored against a behavioural model of the register map and
// timer rules; tick and irq_n are compared against the model every cycle.
`timescale 1ns/1ps
module tb_multi_timer;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int P  = 4;
    localparam int PW = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       irq_n;
    logic       tick;

    multi_timer #(
        .CHANNELS  (CH),
        .WIDTH     (W),
        .PRESCALE  (P),
        .PRESCALE_W(PW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .addr   (addr),
        .wr     (wr),
        .rd     (rd),
        .din    (din),
        .dout   (dout),
        .irq_n  (irq_n),
        .tick   (tick)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Time is counted in clock edges since reset release; a tick is visible
    // whenever that count is a positive multiple of the prescale value.
    longint m_rel  [CH];
    longint m_cnt  [CH];
    longint m_snap [CH];
    bit     m_en   [CH];
    bit     m_auto [CH];
    bit     m_ie   [CH];
    bit     m_casc [CH];
    bit     m_pend [CH];
    bit     m_irq_n;
    int     m_edges;

    function automatic bit tick_now();
        return (m_edges != 0) && ((m_edges % P) == 0);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_rel[c] = 0; m_cnt[c] = 0; m_snap[c] = 0;
            m_en[c] = 0; m_auto[c] = 0; m_ie[c] = 0; m_casc[c] = 0; m_pend[c] = 0;
        end
        m_irq_n = 1'b1;
        m_edges = 0;
    endtask

    task automatic model_step();
        bit tk;
        bit irq_next;
        bit prev_fire;
        bit fire;
        bit step;
        bit hit;
        int c_sel;
        int off;
        tk = tick_now();
        irq_next = 1'b1;
        for (int c = 0; c < CH; c++) if (m_pend[c] && m_ie[c]) irq_next = 1'b0;
        c_sel = int'(addr[6:4]);
        off   = int'(addr[3:0]);
        prev_fire = 1'b0;
        for (int c = 0; c < CH; c++) begin
            hit = !addr[7] && (c_sel == c);
            if (rd && hit && off == 4) m_snap[c] = m_cnt[c];
            if (wr && addr == 8'h80 && din[c]) m_pend[c] = 1'b0;
            step = m_casc[c] ? prev_fire : tk;
            fire = 1'b0;
            if (wr && hit && off == 8) begin
                if ((din[0] && !m_en[c]) || din[3]) m_cnt[c] = m_rel[c];
                m_en[c]   = din[0];
                m_auto[c] = din[1];
                m_ie[c]   = din[2];
`ifdef MULTI_TIMER_CASCADE_EN
                m_casc[c] = (c > 0) && din[4];
`endif
            end else if (m_en[c] && step) begin
                if (m_cnt[c] == 0) begin
                    fire = 1'b1;
                    m_pend[c] = 1'b1;
                    if (m_auto[c]) m_cnt[c] = m_rel[c];
                    else           m_en[c]  = 1'b0;
                end else begin
                    m_cnt[c] = m_cnt[c] - 1;
                end
            end
            if (wr && hit && off < 4) begin
                m_rel[c] = (m_rel[c] & ~(64'hFF << (8 * off))) | (longint'(din) << (8 * off));
                m_rel[c] = m_rel[c] & ((64'd1 << W) - 1);
            end
            prev_fire = fire;
        end
        m_irq_n = irq_next;
        m_edges++;
    endtask

    function automatic logic [7:0] model_read(logic [7:0] a);
        int c;
        int off;
        int v;
        c   = int'(a[6:4]);
        off = int'(a[3:0]);
        if (a == 8'h80) begin
            v = 0;
            for (int i = 0; i < CH; i++) if (m_pend[i]) v |= (1 << i);
            return 8'(v);
        end
        if (a == 8'h81) begin
            v = 0;
            for (int i = 0; i < CH; i++) if (m_pend[i] && m_ie[i]) v |= (1 << i);
            return 8'(v);
        end
        if (a[7] || c >= CH) return 8'h00;
        if (off < 4)  return 8'((m_rel[c] >> (8 * off)) & 255);
        if (off == 4) return 8'(m_cnt[c] & 255);
        if (off < 8)  return 8'((m_snap[c] >> (8 * (off - 4))) & 255);
        if (off == 8) return {3'b000, m_casc[c], 1'b0, m_ie[c], m_auto[c], m_en[c]};
        return 8'h00;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        string      n;
        if (rd) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got %0h with no expectation at %0t", dout, $time);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, 32'(dout), 32'(e));
            end
        end
        check("tick", 32'(tick), 32'(tick_now()));
        check("irq_n", 32'(irq_n), 32'(m_irq_n));
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1ns after a rising edge.
    task automatic op(bit w, bit r, logic [7:0] a, logic [7:0] d);
        addr = a;
        din  = d;
        wr   = w;
        rd   = r;
        if (r) begin
            exp_q.push_back(model_read(a));
            name_q.push_back($sformatf("rd_%02h", a));
        end
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic wreg(logic [7:0] a, logic [7:0] d);
        op(1'b1, 1'b0, a, d);
    endtask

    task automatic rreg(logic [7:0] a);
        op(1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until the current cycle carries a tick that will expire channel c.
    task automatic wait_expiry(int c, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (tick_now() && m_en[c] && !m_casc[c] && m_cnt[c] == 0) begin
                ok = 1'b1;
                return;
            end
            idle(1);
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (tick_now()) begin
                ok = 1'b1;
                return;
            end
            idle(1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int k;
        int ticks;
        int sel;
        logic [7:0] a;
        logic [7:0] d;

        @(posedge clk);
        #1;
        // Reset state, read while reset is held
        rreg(8'h00);
        rreg(8'h04);
        rreg(8'h08);
        rreg(8'h80);
        reset_n = 1'b1;

        // One-shot on channel 0
        wreg(8'h00, 8'd3);
        wreg(8'h08, 8'h05);
        repeat (24) rreg(8'h04);
        rreg(8'h08);
        rreg(8'h80);
        rreg(8'h81);
        idle(2);
        wreg(8'h80, 8'h01);
        idle(2);
        rreg(8'h80);

        // Auto-reload, reload=0, IE=0 on channel 2
        wreg(8'h20, 8'h00);
        wreg(8'h28, 8'h03);
        repeat (10) begin
            rreg(8'h80);
            rreg(8'h81);
        end
        wreg(8'h80, 8'h04);
        rreg(8'h80);

        // W1C of bit1 colliding with channel 1 expiry
        wreg(8'h10, 8'd2);
        wreg(8'h18, 8'h03);
        wreg(8'h80, 8'h02);
        wait_expiry(1, ok);
        if (!ok) timeout_fail("wait_ch1_expiry");
        wreg(8'h80, 8'h02);
        rreg(8'h80);

        // Snapshot consistency on channel 3
        wreg(8'h30, 8'h34);
        wreg(8'h31, 8'h12);
        wreg(8'h32, 8'hAB);
        wreg(8'h38, 8'h01);
        rreg(8'h32);
        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(0, 4));
            rreg(8'h34);
            rreg(8'h35);
        end

        // RESTART in the same cycle as a tick
        wait_tick(ok);
        if (!ok) timeout_fail("wait_tick_restart");
        wreg(8'h38, 8'h09);
        rreg(8'h34);
        rreg(8'h35);
        rreg(8'h38);

        // Reset in the middle of a count of 37, with irq asserted
        wreg(8'h28, 8'h07);
        wreg(8'h00, 8'd40);
        wreg(8'h08, 8'h01);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (m_cnt[0] == 37) ok = 1'b1;
            else idle(1);
        end
        if (!ok) timeout_fail("wait_count_37");
        check("pre_reset_irq_n", 32'(irq_n), 32'd0);
        addr = 8'h04;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_count", 32'(dout), 32'd0);
        check("rst_irq_n", 32'(irq_n), 32'd1);
        check("rst_tick", 32'(tick), 32'd0);
        addr = 8'h80;
        #1;
        check("rst_pending", 32'(dout), 32'd0);
        addr = 8'h08;
        #1;
        check("rst_ctrl", 32'(dout), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        k = 0;
        for (int i = 1; i <= 12 && k == 0; i++) begin
            idle(1);
            if (tick) k = i;
        end
        check("tick_after_reset", 32'(k), 32'(P));
        rreg(8'h08);
        rreg(8'h04);
        idle(8);
        rreg(8'h04);

`ifdef MULTI_TIMER_CASCADE_EN
        // Cascade: ch0 period 2 ticks, ch1 counts ch0 expiries, 3 of them
        wreg(8'h00, 8'd1);
        wreg(8'h10, 8'd2);
        wreg(8'h80, 8'hFF);
        wait_tick(ok);
        if (!ok) timeout_fail("wait_tick_casc");
        wreg(8'h18, 8'h13);
        wreg(8'h08, 8'h03);
        rreg(8'h18);
        addr = 8'h80;
        ticks = 0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            idle(1);
            if (dout[1]) ok = 1'b1;
            else if (tick) ticks++;
        end
        if (!ok) timeout_fail("wait_casc_pending");
        check("casc_ticks", 32'(ticks), 32'd6);
        wreg(8'h08, 8'h10);
        rreg(8'h08);
`else
        wreg(8'h18, 8'h13);
        rreg(8'h18);
        addr = 8'h18;
        #1;
        check("casc_bit_absent", 32'(dout[4]), 32'd0);
        idle(1);
`endif

        // Randomised register traffic
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      a = {1'b0, 3'($urandom_range(0, CH - 1)), 4'($urandom_range(0, 9))};
            else if (sel == 6) a = 8'h80;
            else if (sel == 7) a = 8'h81;
            else if (sel == 8) a = {1'b0, 3'($urandom_range(CH, 7)), 4'($urandom_range(0, 15))};
            else               a = 8'($urandom_range(8'h82, 8'hFF));
            if (a[3:0] == 4'h0 && !a[7]) d = 8'($urandom_range(0, 6));
            else if (a[3:0] < 4 && !a[7]) d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            else d = 8'($urandom);
            k = $urandom_range(0, 9);
            if (k < 4)      wreg(a, d);
            else if (k < 8) rreg(a);
            else            idle(1);
        end

        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
